// File: rtl/prio_arbiter_rr_if.sv
// Request/grant bundle between requesters and prio_arbiter_rr.
// master = requester side, slave = arbiter side.
interface prio_arbiter_rr_if #(
  parameter int N = 8
);
  localparam int IDX_W = $clog2(N);

  logic             rr_mode;
  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             idle;

  modport master (
    output rr_mode,
    output req,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  idle
  );

  modport slave (
    input  rr_mode,
    input  req,
    output grant,
    output grant_idx,
    output grant_valid,
    output idle
  );
endinterface

// File: rtl/prio_arbiter_rr.sv
// Registered N-way arbiter: fixed or round-robin priority,
// grant locked to its owner until release or hold timeout.
module prio_arbiter_rr #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  prio_arbiter_rr_if.slave bus
);
  localparam int IDX_W = $clog2(N);
  localparam int HC_W  = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HC_MAX =
    HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N - 1);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic             valid_q, valid_d;
  logic             idle_q, idle_d;

  logic [N-1:0]     cand;
  logic [IDX_W-1:0] top;
  logic [IDX_W-1:0] win;
  logic             issue;
  logic             timeout;

  // Current owner never competes against itself; in IDLE grant is 0.
  assign cand = bus.req & ~grant_q;

  // Winner: first set bit of cand scanning down from top, wrapping.
  always_comb begin
    int p;
    p   = 0;
    top = bus.rr_mode ? ptr_q : PTR_RST;
    win = '0;
    for (int k = N - 1; k >= 0; k--) begin
      p = int'(top) - k;
      if (p < 0) p = p + N;
      if (cand[p[IDX_W-1:0]]) win = IDX_W'(p);
    end
  end

  // Next-state: hold, release, timeout rotation, or new grant.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    idle_d  = idle_q;
    issue   = 1'b0;
    timeout = (MAX_HOLD > 0) && (hold_q == HC_MAX);
    unique case (state_q)
      S_IDLE: issue = |bus.req;
      S_GRANT: begin
        if (~|(bus.req & grant_q)) begin
          if (|cand) begin
            issue = 1'b1;
          end else begin
            state_d = S_IDLE;
            grant_d = '0;
            idx_d   = '0;
            hold_d  = '0;
            valid_d = 1'b0;
            idle_d  = 1'b1;
          end
        end else if (timeout && |cand) begin
          issue = 1'b1;
        end else if (hold_q != HC_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (issue) begin
      state_d = S_GRANT;
      grant_d = ONE << win;
      idx_d   = win;
      hold_d  = '0;
      valid_d = 1'b1;
      idle_d  = 1'b0;
      ptr_d   = (win == '0) ? PTR_RST : win - 1'b1;
    end
  end

  // State and output registers; reset drops the grant at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= PTR_RST;
      hold_q  <= '0;
      valid_q <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      idle_q  <= idle_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;
  assign bus.idle        = idle_q;
endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Bench for prio_arbiter_rr: N=8/MAX_HOLD=4 and N=16/MAX_HOLD=16
// instances against a per-cycle behavioural model.
module tb_prio_arbiter_rr;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0;
  int bad = 0;

  prio_arbiter_rr_if #(.N(8))  bus8();
  prio_arbiter_rr_if #(.N(16)) bus16();

  prio_arbiter_rr #(.N(8), .MAX_HOLD(4)) dut8 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus8)
  );

  prio_arbiter_rr #(.N(16), .MAX_HOLD(16)) dut16 (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus16)
  );

  always #5 clk = ~clk;

  // model: owner (-1 = none), pointer, cycles the owner has held
  int m_own[2];
  int m_ptr[2];
  int m_held[2];
  int m_n[2]  = '{8, 16};
  int m_mh[2] = '{4, 16};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void mstep(int d, logic [31:0] r, bit mode);
    logic [31:0] oth;
    bit go;
    bit found;
    int top;
    int idx;
    int n;
    n = m_n[d];
    oth = r;
    go = 1'b0;
    if (m_own[d] >= 0) oth[m_own[d]] = 1'b0;
    if (m_own[d] < 0) begin
      go = (r != 0);
    end else if (!r[m_own[d]]) begin
      if (oth != 0) go = 1'b1;
      else begin
        m_own[d] = -1;
        m_held[d] = 0;
      end
    end else if (m_mh[d] > 0 && m_held[d] >= m_mh[d] && oth != 0) begin
      go = 1'b1;
    end else if (m_held[d] < 1000) begin
      m_held[d]++;
    end
    if (go) begin
      top = mode ? m_ptr[d] : n - 1;
      found = 1'b0;
      for (int k = 0; k < n; k++) begin
        idx = (top - k + n) % n;
        if (!found && oth[idx]) begin
          found = 1'b1;
          m_own[d] = idx;
          m_ptr[d] = (idx + n - 1) % n;
          m_held[d] = 1;
        end
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_own[d] = -1;
        m_ptr[d] = m_n[d] - 1;
        m_held[d] = 0;
      end
    end else begin
      mstep(0, 32'(bus8.req), bus8.rr_mode);
      mstep(1, 32'(bus16.req), bus16.rr_mode);
    end
  end

  function automatic logic [31:0] exp8();
    if (m_own[0] < 0) return 32'({8'h00, 3'd0, 1'b0, 1'b1});
    return 32'({8'(1 << m_own[0]), 3'(m_own[0]), 2'b10});
  endfunction

  function automatic logic [31:0] exp16();
    if (m_own[1] < 0) return 32'({16'h0000, 4'd0, 1'b0, 1'b1});
    return 32'({16'(1 << m_own[1]), 4'(m_own[1]), 2'b10});
  endfunction

  // per-cycle compare of both instances against the model
  always @(negedge clk) begin
    chk("model8", 32'({bus8.grant, bus8.grant_idx,
                       bus8.grant_valid, bus8.idle}), exp8());
    chk("model16", 32'({bus16.grant, bus16.grant_idx,
                        bus16.grant_valid, bus16.idle}), exp16());
  end

  task automatic tick(int k = 1);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_rst();
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    bus8.req = '0;
    bus8.rr_mode = 1'b0;
    bus16.req = '0;
    bus16.rr_mode = 1'b0;
    #1 rst_n = 1'b0;
    #12 rst_n = 1'b1;
    tick();
    chk("rst_idle", 32'(bus8.idle), 32'd1);
    chk("rst_grant", 32'(bus8.grant), 32'd0);

    bus8.req = 8'hA4;
    tick();
    chk("fx_grant", 32'(bus8.grant), 32'h80);
    chk("fx_idx", 32'(bus8.grant_idx), 32'd7);
    chk("fx_idle", 32'(bus8.idle), 32'd0);
    bus8.req = 8'h24;
    tick();
    chk("fx_move_idx", 32'(bus8.grant_idx), 32'd5);
    chk("fx_no_bubble", 32'(bus8.grant_valid), 32'd1);
    bus8.req = 8'h00;
    tick();
    chk("fx_to_idle", 32'(bus8.idle), 32'd1);

    pulse_rst();
    bus8.rr_mode = 1'b1;
    bus8.req = 8'hFF;
    for (int c = 0; c < 36; c++) begin
      tick();
      chk("rr_rotate", 32'(bus8.grant_idx), 32'((15 - c / 4) % 8));
    end
    bus8.req = 8'h00;
    tick();

    bus8.req = 8'h24;
    tick();
    chk("pulse_a", 32'(bus8.grant_idx), 32'd5);
    bus8.req = 8'h04;
    tick();
    chk("pulse_b", 32'(bus8.grant_idx), 32'd2);
    bus8.req = 8'h24;
    tick();
    chk("pulse_hold2", 32'(bus8.grant_idx), 32'd2);
    bus8.req = 8'h20;
    tick();
    chk("pulse_c", 32'(bus8.grant_idx), 32'd5);
    bus8.req = 8'h24;
    tick();
    bus8.req = 8'h04;
    tick();
    chk("pulse_d", 32'(bus8.grant_idx), 32'd2);
    bus8.req = 8'h00;
    tick();
    bus8.req = 8'h24;
    tick();
    chk("ptr_after_2", 32'(bus8.grant_idx), 32'd5);
    bus8.req = 8'h00;
    tick();

    pulse_rst();
    bus16.rr_mode = 1'b1;
    bus16.req = 16'h8001;
    tick();
    chk("n16_first", 32'(bus16.grant_idx), 32'd15);
    bus16.req = 16'h0001;
    tick();
    chk("n16_zero", 32'(bus16.grant_idx), 32'd0);
    bus16.req = 16'h0000;
    tick();
    bus16.req = 16'h8001;
    tick();
    chk("n16_wrap", 32'(bus16.grant_idx), 32'd15);
    bus16.req = 16'h0000;
    tick();

    bus16.req = 16'h0008;
    for (int c = 0; c < 40; c++) begin
      tick();
      chk("single_hold", 32'(bus16.grant_idx), 32'd3);
    end
    bus16.req = 16'h0000;
    tick();
    chk("single_idle", 32'(bus16.idle), 32'd1);
    chk("single_idx0", 32'(bus16.grant_idx), 32'd0);

    pulse_rst();
    bus8.req = 8'h40;
    tick();
    chk("pre_rst_idx", 32'(bus8.grant_idx), 32'd6);
    #1 rst_n = 1'b0;
    #1;
    chk("async_grant", 32'(bus8.grant), 32'd0);
    chk("async_idle", 32'(bus8.idle), 32'd1);
    bus8.req = 8'h41;
    #1 rst_n = 1'b1;
    tick();
    chk("ptr_rst", 32'(bus8.grant_idx), 32'd6);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) bus8.req = 8'($urandom);
      if ($urandom_range(0, 3) == 0)
        bus16.req = 16'($urandom & $urandom);
      if ($urandom_range(0, 15) == 0) bus8.rr_mode = ~bus8.rr_mode;
      if ($urandom_range(0, 15) == 0) bus16.rr_mode = ~bus16.rr_mode;
      if ($urandom_range(0, 199) == 0) pulse_rst();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prio_arbiter_rr.md
Name: prio_arbiter_rr

Overview:
- Parametrised, registered successor to the 8-to-3 combinational priority encoder.
- Arbitrates N request lines into one one-hot grant, one binary grant index and an idle flag.
- Two arbitration modes:
  - fixed priority: highest index wins.
  - round-robin with a rotating pointer.
- Grants lock to their owner until released or until a hold timeout forces rotation.
- Sits in front of shared resources (bus, memory port) driven by multiple lab-level requesters.

Parameters:
- N, 8: number of requesters; legal range 2..32.
- MAX_HOLD, 16: maximum consecutive cycles one owner may keep the grant while others wait. 0 disables the timeout.
- IDX_W, $clog2(N): localparam, width of grant_idx and the RR pointer; not overridable.

Ports:
- clk  input  1  single rising-edge clock.
- rst_n  input  1  asynchronous active-low reset; deassertion synchronous to clk is the integrator's responsibility.
- rr_mode  input  1  0 = fixed priority, 1 = round-robin; sampled at every arbitration edge.
- req  input  N  request lines; a requester holds its bit high for the duration of its transaction.
- grant  output  N  registered one-hot grant; all-zero when idle.
- grant_idx  output  IDX_W  registered binary index of the owner; 0 when idle (never z/x).
- grant_valid  output  1  registered; 1 iff grant != 0.
- idle  output  1  registered; equals ~grant_valid.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: grant=0, grant_idx=0, grant_valid=0, idle=1.
  - Internal: state=IDLE, rr_ptr=N-1, hold_cnt=0.
- Latency: 1 cycle. A req sampled at edge k produces grant visible after edge k; no combinational req->grant path.
- Winner selection (combinational, over a candidate vector cand):
  - Fixed mode: highest set index of cand.
  - RR mode: search order rr_ptr, rr_ptr-1, ..., 0, N-1, ..., rr_ptr+1; first set bit wins.
  - With rr_ptr=N-1, RR behaves identically to fixed mode.
- State IDLE:
  - req==0: stay IDLE, outputs unchanged.
  - req!=0: cand=req; register winner w (grant=1<<w, grant_idx=w, grant_valid=1, idle=0); hold_cnt=0; go to GRANT.
- State GRANT (owner o):
  - req[o]=1 and no timeout: hold grant; hold_cnt increments and saturates at MAX_HOLD-1.
  - req[o]=0 (release):
    - cand=req with bit o cleared.
    - cand!=0: grant moves directly to the new winner on the same edge (no idle bubble); hold_cnt=0.
    - cand==0: return to IDLE with outputs at their reset values.
  - Timeout (MAX_HOLD>0, hold_cnt==MAX_HOLD-1, req[o]=1, and (req & ~(1<<o))!=0): treated as a release. cand excludes o; grant moves to the winner; hold_cnt=0.
  - Timeout condition with no other requester: keep the grant, hold_cnt stays saturated, and re-check every cycle.
- rr_ptr update: on every edge that issues a new grant to w, rr_ptr = (w-1) mod N, regardless of mode. w=0 wraps to N-1.
- Mode change takes effect at the next arbitration only; it never revokes a held grant.
- Reset mid-grant: grant drops asynchronously, and the pointer returns to N-1.
- Grant is always one-hot or zero; grant_idx is always consistent with grant in the same cycle.

Test Plan:
- Reset then req=8'b1010_0100, rr_mode=0 -> one edge later grant=8'b1000_0000, grant_idx=7, idle=0. Drop req[7] -> next edge grant_idx=5, no idle cycle.
- rr_mode=1, req=8'hFF held constant, MAX_HOLD=4 -> owners 7,6,5,...,0,7 in sequence, each held exactly 4 cycles, no gaps.
- rr_mode=1, req bits 2 and 5 toggled as single-cycle-release pulses -> grants alternate 5,2,5,2. Pointer after granting 2 is 1, so 5 wins the next contention.
- Single requester req=8'b0000_1000 held 40 cycles with MAX_HOLD=16 -> grant_idx=3 continuously, no drop at timeout. Then req=0 -> idle=1, grant_idx=0 next edge.
- rst_n pulsed low mid-grant (grant_idx=6) -> grant=0 and idle=1 immediately without waiting for clk. After release, req=8'h41 in RR mode -> grant_idx=6 (pointer reset to 7).
- N=16 build, req=16'h8001, rr_mode=1 -> grants 15 then 0 on release. Pointer wrap: after granting 0, rr_ptr=15.
